// File: rtl/elevator_ctrl_n.sv
// Single-car SCAN elevator controller: call latching, dispatch, door sequencing.
// Optional idle parking to floor 0 is enabled by defining PARK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | doors closed, motor stopped, choosing the next call
// S_MOVE    | motor running in dir, counting floor_pulse landings
// S_ARRIVE  | one-cycle stop: chime, clear served lamps
// S_OPENING | door actuator opening until door_is_open
// S_HOLD    | doors open, hold timer counting down
// S_CLOSING | door actuator closing until door_is_closed
module elevator_ctrl_n #(
    parameter int FLOORS     = 4,
    parameter int FLOOR_W    = 2,
    parameter int DOOR_TICKS = 8,
    parameter int PARK_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  hall_up,
    input  logic [FLOORS-1:0]  hall_dn,
    input  logic [FLOORS-1:0]  car_call,
    input  logic               door_open_btn,
    input  logic               door_close_btn,
    input  logic               floor_pulse,
    input  logic               door_is_open,
    input  logic               door_is_closed,
    input  logic               door_obstruct,
    output logic [FLOORS-1:0]  lamp_up,
    output logic [FLOORS-1:0]  lamp_dn,
    output logic [FLOORS-1:0]  lamp_car,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir,
    output logic [1:0]         motor,
    output logic [1:0]         door_cmd,
    output logic [1:0]         chime
);

    localparam int TIMER_W = $clog2(DOOR_TICKS + 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(DOOR_TICKS);
    localparam logic [FLOORS-1:0]  UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]  DN_MASK   = {{(FLOORS-1){1'b1}}, 1'b0};

    if (FLOOR_W != $clog2(FLOORS) || FLOORS < 2 || DOOR_TICKS < 1 || PARK_TICKS < 1) begin : g_bad_param
        $error("elevator_ctrl_n: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_ARRIVE, S_OPENING, S_HOLD, S_CLOSING
    } state_t;

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d, next_floor;
    logic                dir_q, dir_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [FLOORS-1:0]   lamp_up_q, lamp_dn_q, lamp_car_q;
    logic [FLOORS-1:0]   lamp_up_d, lamp_dn_d, lamp_car_d;
    logic [FLOORS-1:0]   park_call, car_eff, calls, here_bit, clr_bit;
    logic [FLOORS-1:0]   up_press, dn_press;
    logic                serving, press_here, at_end;
    logic                ahead, behind, here, dir_here;
    logic                nf_ahead, nf_dir, nf_opp;

    function automatic logic any_above(input logic [FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] sel;
        sel = ({FLOORS{1'b1}} << f) << 1;
        return |(m & sel);
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] sel;
        sel = ~({FLOORS{1'b1}} << f);
        return |(m & sel);
    endfunction

    assign up_press = hall_up & UP_MASK;
    assign dn_press = hall_dn & DN_MASK;
    assign car_eff  = lamp_car_q | park_call;
    assign calls    = lamp_up_q | lamp_dn_q | car_eff;
    assign here_bit = FLOORS'(1) << floor_q;

    // Calls at the landing are served while stopped there with doors in use.
    assign serving    = (state_q == S_ARRIVE) || (state_q == S_OPENING) || (state_q == S_HOLD);
    assign clr_bit    = serving ? here_bit : '0;
    assign press_here = |(here_bit & (car_call | (dir_q ? up_press : dn_press)));

    assign lamp_car_d = (lamp_car_q | car_call) & ~clr_bit;
    assign lamp_up_d  = (lamp_up_q | up_press) & ~(dir_q ? clr_bit : '0);
    assign lamp_dn_d  = (lamp_dn_q | dn_press) & ~(dir_q ? '0 : clr_bit);

`ifdef PARK_EN
    localparam int PARK_W = $clog2(PARK_TICKS + 1);
    logic [PARK_W-1:0] park_cnt_q;
    logic              park_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            park_cnt_q <= '0;
            park_req_q <= 1'b0;
        end else if (|(lamp_up_q | lamp_dn_q | lamp_car_q)) begin
            park_cnt_q <= '0;
            park_req_q <= 1'b0;
        end else if (state_q == S_ARRIVE && floor_q == '0) begin
            park_req_q <= 1'b0;
        end else if (state_q != S_IDLE) begin
            park_cnt_q <= '0;
        end else if (!park_req_q && floor_q != '0) begin
            if (park_cnt_q == PARK_W'(PARK_TICKS - 1)) begin
                park_req_q <= 1'b1;
                park_cnt_q <= '0;
            end else begin
                park_cnt_q <= park_cnt_q + 1'b1;
            end
        end
    end

    assign park_call = {{(FLOORS-1){1'b0}}, park_req_q};
`else
    assign park_call = '0;
`endif

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        at_end     = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
        ahead      = dir_q ? any_above(calls, floor_q) : any_below(calls, floor_q);
        behind     = dir_q ? any_below(calls, floor_q) : any_above(calls, floor_q);
        here       = |(calls & here_bit);
        dir_here   = |((dir_q ? lamp_up_q : lamp_dn_q) & here_bit);
        next_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
        nf_ahead   = dir_q ? any_above(calls, next_floor) : any_below(calls, next_floor);
        nf_dir     = dir_q ? lamp_up_q[next_floor] : lamp_dn_q[next_floor];
        nf_opp     = dir_q ? lamp_dn_q[next_floor] : lamp_up_q[next_floor];

        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d = S_OPENING;
                    // Only an opposite hall call is waiting here: turn round to serve it.
                    if (!dir_here && !(|(car_eff & here_bit)))
                        dir_d = ~dir_q;
                end else if (ahead) begin
                    state_d = S_MOVE;
                end else if (behind) begin
                    dir_d   = ~dir_q;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                if (floor_pulse && !at_end) begin
                    floor_d = next_floor;
                    if (car_eff[next_floor] || nf_dir || !nf_ahead)
                        state_d = S_ARRIVE;
                    if (!nf_ahead && !nf_dir && nf_opp)
                        dir_d = ~dir_q;
                end
            end
            S_ARRIVE: state_d = S_OPENING;
            S_OPENING: begin
                if (door_is_open) begin
                    state_d = S_HOLD;
                    timer_d = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (door_open_btn || door_obstruct || press_here) begin
                    timer_d = HOLD_LOAD;
                end else if (door_close_btn || timer_q <= TIMER_W'(1)) begin
                    state_d = S_CLOSING;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CLOSING: begin
                if (door_obstruct || door_open_btn)
                    state_d = S_OPENING;
                else if (door_is_closed)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            timer_q    <= '0;
            lamp_up_q  <= '0;
            lamp_dn_q  <= '0;
            lamp_car_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            lamp_up_q  <= lamp_up_d;
            lamp_dn_q  <= lamp_dn_d;
            lamp_car_q <= lamp_car_d;
        end
    end

    assign lamp_up  = lamp_up_q;
    assign lamp_dn  = lamp_dn_q;
    assign lamp_car = lamp_car_q;
    assign floor    = floor_q;
    assign dir      = dir_q;
    assign motor    = (state_q == S_MOVE) ? (dir_q ? 2'b01 : 2'b10) : 2'b00;
    assign door_cmd = (state_q == S_OPENING) ? 2'b01 :
                      (state_q == S_CLOSING) ? 2'b10 : 2'b00;
    assign chime    = (state_q == S_ARRIVE) ? (dir_q ? 2'b01 : 2'b10) : 2'b00;

endmodule
